// File: rtl/fifo_rd_pixel_ctrl_if.sv
// Bus bundle between the pixel read sequencer, the async FIFO read port
// and the VGA timing/output stage.
//
// Handshake semantics: fifo_r_en is a pop request that the FIFO honours
// only while fifo_empty is low. The sequencer never raises it while
// fifo_empty is high. fifo_rdata is valid the cycle after an honoured pop.
// pix_valid qualifies pix_data for exactly one cycle. The VGA side has no
// ready/backpressure, because the pixel clock never stalls.
interface fifo_rd_pixel_ctrl_if #(
  parameter int DATA_W = 16
);
  logic              vga_frame_start;
  logic              pix_req;
  logic              fifo_empty;
  logic [DATA_W-1:0] fifo_rdata;
  logic              fifo_r_en;
  logic [DATA_W-1:0] pix_data;
  logic              pix_valid;
  logic              frame_done;

  // Timing generator and FIFO side: drives requests and read data.
  modport master (
    output vga_frame_start,
    output pix_req,
    output fifo_empty,
    output fifo_rdata,
    input  fifo_r_en,
    input  pix_data,
    input  pix_valid,
    input  frame_done
  );

  // Read sequencer side.
  modport slave (
    input  vga_frame_start,
    input  pix_req,
    input  fifo_empty,
    input  fifo_rdata,
    output fifo_r_en,
    output pix_data,
    output pix_valid,
    output frame_done
  );
endinterface

// File: rtl/fifo_rd_pixel_ctrl.sv
// Read-side sequencer for the camera-to-VGA async FIFO (pixel clock domain).
// Pops one word per active pixel request once a frame has started. It
// substitutes FILL_COLOR when the FIFO is empty and keeps underrun and
// desync statistics.
module fifo_rd_pixel_ctrl #(
  parameter int                DATA_W     = 16,
  parameter int                H_ACTIVE   = 640,
  parameter int                V_ACTIVE   = 480,
  parameter logic [DATA_W-1:0] FILL_COLOR = '0
) (
  input  logic                 rclk,
  input  logic                 rrst_n,
  input  logic                 enable,
  input  logic                 clr_stats,
  fifo_rd_pixel_ctrl_if.slave  bus,
  output logic                 underrun,
  output logic                 desync,
  output logic [15:0]          underrun_cnt,
  output logic [1:0]           state
);

  localparam int XW = (H_ACTIVE > 1) ? $clog2(H_ACTIVE) : 1;
  localparam int YW = (V_ACTIVE > 1) ? $clog2(V_ACTIVE) : 1;
  localparam logic [XW-1:0] X_LAST = XW'(H_ACTIVE - 1);
  localparam logic [YW-1:0] Y_LAST = YW'(V_ACTIVE - 1);

  typedef enum logic [1:0] {
    IDLE       = 2'd0,
    WAIT_FRAME = 2'd1,
    STREAM     = 2'd2,
    FINISH     = 2'd3
  } state_t;

  state_t          state_q;
  state_t          state_d;
  logic [XW-1:0]   x_q;
  logic [YW-1:0]   y_q;
  logic            src_fifo_q;
  logic            pix_valid_q;

  logic            serviced;
  logic            underrun_evt;
  logic            desync_evt;
  logic            last_req;
  logic            start_frame;

  assign state = state_q;

  // State register; reset drops straight to IDLE without a frame_done.
  always_ff @(posedge rclk or negedge rrst_n) begin
    if (!rrst_n) state_q <= IDLE;
    else         state_q <= state_d;
  end

  // Next-state logic; enable only gates frame entry, never aborts a frame.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:       if (enable) state_d = WAIT_FRAME;
      WAIT_FRAME: begin
        if (!enable)                   state_d = IDLE;
        else if (bus.vga_frame_start)  state_d = STREAM;
      end
      STREAM:     if (!bus.vga_frame_start && last_req) state_d = FINISH;
      FINISH:     state_d = enable ? WAIT_FRAME : IDLE;
      default:    state_d = IDLE;
    endcase
  end

  // Output and event decode; the FIFO pop is combinational with pix_req.
  always_comb begin
    serviced      = (state_q == STREAM) && bus.pix_req;
    bus.fifo_r_en = serviced && !bus.fifo_empty;
    underrun_evt  = serviced && bus.fifo_empty;
    desync_evt    = (state_q == STREAM) && bus.vga_frame_start;
    start_frame   = (state_q == WAIT_FRAME) && enable && bus.vga_frame_start;
    last_req      = bus.pix_req && (x_q == X_LAST) && (y_q == Y_LAST);
    bus.frame_done = (state_q == FINISH);
  end

  // Pixel position; a mid-frame frame_start restarts at (0,0) and any
  // request in that same cycle is taken as pixel (0,0).
  always_ff @(posedge rclk or negedge rrst_n) begin
    if (!rrst_n) begin
      x_q <= '0;
      y_q <= '0;
    end else if (start_frame) begin
      x_q <= '0;
      y_q <= '0;
    end else if (desync_evt) begin
      x_q <= (bus.pix_req && (X_LAST != '0)) ? XW'(1) : '0;
      y_q <= '0;
    end else if (serviced) begin
      if (x_q == X_LAST) begin
        x_q <= '0;
        y_q <= (y_q == Y_LAST) ? '0 : y_q + 1'b1;
      end else begin
        x_q <= x_q + 1'b1;
      end
    end
  end

  // Pixel source capture: one cycle after each serviced request.
  always_ff @(posedge rclk or negedge rrst_n) begin
    if (!rrst_n) begin
      pix_valid_q <= 1'b0;
      src_fifo_q  <= 1'b0;
    end else begin
      pix_valid_q <= serviced;
      src_fifo_q  <= serviced && !bus.fifo_empty;
    end
  end

  // Pixel mux: FIFO word for real pops, fill colour for underruns.
  always_comb begin
    bus.pix_valid = pix_valid_q;
    bus.pix_data  = '0;
    if (pix_valid_q) bus.pix_data = src_fifo_q ? bus.fifo_rdata : FILL_COLOR;
  end

  // Statistics; a clear in the same cycle as an event wins.
  always_ff @(posedge rclk or negedge rrst_n) begin
    if (!rrst_n) begin
      underrun     <= 1'b0;
      desync       <= 1'b0;
      underrun_cnt <= '0;
    end else if (clr_stats) begin
      underrun     <= 1'b0;
      desync       <= 1'b0;
      underrun_cnt <= '0;
    end else begin
      if (underrun_evt) begin
        underrun <= 1'b1;
        if (underrun_cnt != 16'hFFFF) underrun_cnt <= underrun_cnt + 16'd1;
      end
      if (desync_evt) desync <= 1'b1;
    end
  end

endmodule

// File: tb/tb_fifo_rd_pixel_ctrl.sv
// Directed bench for fifo_rd_pixel_ctrl with a 4x2 frame and a small FIFO
// model. Expected pixels are the hand-loaded FIFO words or the fill colour.
module tb_fifo_rd_pixel_ctrl;

  localparam logic [15:0] FILL = 16'hABCD;

  // ---------------- clock / reset ----------------
  logic        rclk = 1'b0;
  logic        rrst_n;
  logic        enable;
  logic        clr_stats;
  logic        underrun;
  logic        desync;
  logic [15:0] underrun_cnt;
  logic [1:0]  state;

  always #5 rclk = ~rclk;

  fifo_rd_pixel_ctrl_if #(.DATA_W(16)) bus ();

  fifo_rd_pixel_ctrl #(
    .DATA_W(16), .H_ACTIVE(4), .V_ACTIVE(2), .FILL_COLOR(FILL)
  ) dut (
    .rclk(rclk), .rrst_n(rrst_n), .enable(enable), .clr_stats(clr_stats),
    .bus(bus), .underrun(underrun), .desync(desync),
    .underrun_cnt(underrun_cnt), .state(state)
  );

  // ---------------- FIFO model ----------------
  logic [15:0] fifo_mem [0:15];
  int          fifo_rd = 0;
  int          fifo_wr = 0;

  assign bus.fifo_empty = (fifo_rd == fifo_wr);

  always @(posedge rclk) begin
    if (bus.fifo_r_en) begin
      bus.fifo_rdata <= fifo_mem[fifo_rd & 15];
      fifo_rd        <= fifo_rd + 1;
    end
  end

  task automatic fifo_load(input int n, input logic [15:0] base);
    for (int i = 0; i < n; i++) fifo_mem[(fifo_rd + i) & 15] = base + 16'(i);
    fifo_wr = fifo_rd + n;
  endtask

  // ---------------- scoreboard ----------------
  int n_vec = 0;
  int n_err = 0;
  int pops  = 0;
  int fds   = 0;
  logic [15:0] exp_q[$];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // ---------------- driver tasks ----------------
  // One clock: drive at negedge, check the combinational pop, then step
  // past the posedge so registered outputs can be sampled.
  task automatic step(input logic req, input logic fs, input logic en,
                      input logic clr, input logic exp_ren);
    @(negedge rclk);
    bus.pix_req         = req;
    bus.vga_frame_start = fs;
    enable              = en;
    clr_stats           = clr;
    #1;
    check("r_en", bus.fifo_r_en, exp_ren);
    if (bus.fifo_r_en)  pops++;
    if (bus.frame_done) fds++;
    @(posedge rclk);
    #1;
  endtask

  // Serviced request; the expected pixel goes through the queue.
  task automatic req_px(input logic en, input logic exp_ren, input logic [15:0] px);
    exp_q.push_back(px);
    step(1'b1, 1'b0, en, 1'b0, exp_ren);
    check("pix_valid", bus.pix_valid, 1'b1);
    check("pix_data", bus.pix_data, exp_q.pop_front());
  endtask

  int p0, f0;

  initial begin
    rrst_n = 1'b0; enable = 1'b0; clr_stats = 1'b0;
    bus.pix_req = 1'b0; bus.vga_frame_start = 1'b0; bus.fifo_rdata = '0;
    repeat (2) @(posedge rclk);
    #1;
    check("rst_state", state, 2'd0);
    check("rst_r_en", bus.fifo_r_en, 1'b0);
    check("rst_pv", bus.pix_valid, 1'b0);
    check("rst_pd", bus.pix_data, 16'h0);
    check("rst_fd", bus.frame_done, 1'b0);
    check("rst_ur", underrun, 1'b0);
    check("rst_ds", desync, 1'b0);
    check("rst_cnt", underrun_cnt, 16'h0);
    @(negedge rclk); rrst_n = 1'b1;

    // Normal frame, with early requests in WAIT_FRAME ignored
    fifo_load(8, 16'h0001);
    step(0, 0, 1, 0, 0);
    check("n_wait", state, 2'd1);
    step(1, 0, 1, 0, 0);
    check("pre_pv", bus.pix_valid, 1'b0);
    step(1, 0, 1, 0, 0);
    check("pre_pv2", bus.pix_valid, 1'b0);
    p0 = pops; f0 = fds;
    step(0, 1, 1, 0, 0);
    check("n_stream", state, 2'd2);
    for (int i = 0; i < 8; i++) begin
      req_px(1, 1, 16'(i + 1));
      if (i < 7) check("n_fd_early", bus.frame_done, 1'b0);
    end
    check("n_fd", bus.frame_done, 1'b1);
    step(1, 0, 1, 0, 0);           // request during FINISH is ignored
    check("n_after", state, 2'd1);
    check("n_fin_pv", bus.pix_valid, 1'b0);
    check("n_cnt", underrun_cnt, 16'h0);
    check("n_ur", underrun, 1'b0);
    check("n_pops", pops - p0, 8);
    check("n_fds", fds - f0, 1);

    // Underrun: only 5 words
    fifo_load(5, 16'h0011);
    step(0, 1, 1, 0, 0);
    for (int i = 0; i < 5; i++) req_px(1, 1, 16'h0011 + 16'(i));
    check("u_ur0", underrun, 1'b0);
    for (int i = 0; i < 3; i++) req_px(1, 0, FILL);
    check("u_ur", underrun, 1'b1);
    check("u_cnt", underrun_cnt, 16'd3);
    check("u_fd", bus.frame_done, 1'b1);
    step(0, 0, 1, 0, 0);
    step(0, 0, 1, 1, 0);
    check("clr_cnt", underrun_cnt, 16'd0);
    check("clr_ur", underrun, 1'b0);

    // Mid-frame resync
    fifo_load(11, 16'h0021);
    f0 = fds;
    step(0, 1, 1, 0, 0);
    for (int i = 0; i < 3; i++) req_px(1, 1, 16'h0021 + 16'(i));
    step(0, 1, 1, 0, 0);
    check("r_ds", desync, 1'b1);
    check("r_state", state, 2'd2);
    for (int i = 0; i < 8; i++) begin
      req_px(1, 1, 16'h0024 + 16'(i));
      if (i < 7) check("r_fd_early", bus.frame_done, 1'b0);
    end
    check("r_fin", state, 2'd3);
    step(0, 0, 1, 0, 0);
    check("r_fds", fds - f0, 1);
    check("r_ds_sticky", desync, 1'b1);
    step(0, 0, 1, 1, 0);
    check("r_ds_clr", desync, 1'b0);

    // Enable drop after request 2
    fifo_load(8, 16'h0031);
    f0 = fds;
    step(0, 1, 1, 0, 0);
    for (int i = 0; i < 2; i++) req_px(1, 1, 16'h0031 + 16'(i));
    for (int i = 2; i < 8; i++) req_px(0, 1, 16'h0031 + 16'(i));
    check("e_fd", bus.frame_done, 1'b1);
    step(0, 0, 0, 0, 0);
    check("e_idle", state, 2'd0);
    check("e_fds", fds - f0, 1);
    step(0, 1, 0, 0, 0);
    check("e_ign_fs", state, 2'd0);
    step(1, 0, 0, 0, 0);
    check("e_pv", bus.pix_valid, 1'b0);

    // Reset mid-frame
    fifo_load(1, 16'h0041);
    step(0, 0, 1, 0, 0);
    step(0, 1, 1, 0, 0);
    req_px(1, 1, 16'h0041);
    req_px(1, 0, FILL);
    step(0, 1, 1, 0, 0);
    check("m_pre_ur", underrun, 1'b1);
    check("m_pre_ds", desync, 1'b1);
    check("m_pre_cnt", underrun_cnt, 16'd1);
    @(negedge rclk);
    bus.pix_req = 1'b1;
    rrst_n = 1'b0;
    #1;
    check("m_state", state, 2'd0);
    check("m_r_en", bus.fifo_r_en, 1'b0);
    check("m_fd", bus.frame_done, 1'b0);
    check("m_ur", underrun, 1'b0);
    check("m_ds", desync, 1'b0);
    check("m_cnt", underrun_cnt, 16'd0);
    @(negedge rclk);
    bus.pix_req = 1'b0;
    rrst_n = 1'b1;

    // Clear beats a same-cycle underrun, then saturation
    step(0, 0, 1, 0, 0);
    step(0, 1, 1, 0, 0);
    exp_q.push_back(FILL);
    step(1, 0, 1, 1, 0);
    check("c_pv", bus.pix_valid, 1'b1);
    check("c_pd", bus.pix_data, exp_q.pop_front());
    check("c_ur", underrun, 1'b0);
    check("c_cnt", underrun_cnt, 16'd0);
    for (int i = 0; i < 65535; i++) begin
      @(negedge rclk);
      bus.pix_req         = 1'b1;
      bus.vga_frame_start = (i % 7 == 0);
      clr_stats           = 1'b0;
    end
    @(posedge rclk);
    #1;
    check("s_cnt_ffff", underrun_cnt, 16'hFFFF);
    check("s_state", state, 2'd2);
    step(1, 0, 1, 0, 0);
    step(1, 0, 1, 0, 0);
    check("s_sat", underrun_cnt, 16'hFFFF);
    check("s_ur", underrun, 1'b1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
